notas_xylo: RTL and testbench

//  Xylophone note display decoder. Captures a 4-bit note code {a,b,c,d} when

---
 rtl/notas_xylo.sv | 66 ++++++
 tb/tb_notas_xylo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/notas_xylo.sv
// Xylophone note decoder: captures {a,b,c,d} on ready and drives a 7-segment note letter; one-edge latency.
// No backpressure: ready is a plain load strobe and outputs hold between loads; reset blanks immediately.
module notas_xylo #(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic ready,
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic s0,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic s4,
  output logic s5,
  output logic s6
);

  localparam logic [6:0] SEG_MASK = {7{SEG_ACTIVE_LOW}};

  logic [1:0] rst_sync_q;
  logic [3:0] code;
  logic [6:0] seg_dat;
  logic [6:0] seg_q;

  assign code = {a, b, c, d};

  // Release is held off for two edges so the first load never races reset removal.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  // Bit 6 is segment a (s0), bit 0 is segment g (s6); the octave bit does not change the letter.
  always_comb begin
    seg_dat = 7'b0000001;
    case (code)
      4'd0, 4'd8:  seg_dat = 7'b1001110;
      4'd1, 4'd9:  seg_dat = 7'b0111101;
      4'd2, 4'd10: seg_dat = 7'b1001111;
      4'd3, 4'd11: seg_dat = 7'b1000111;
      4'd4, 4'd12: seg_dat = 7'b1011110;
      4'd5, 4'd13: seg_dat = 7'b1110111;
      4'd6, 4'd14: seg_dat = 7'b0011111;
      default:     seg_dat = 7'b0000001;
    endcase
  end

  // Polarity is folded in before the flop so the pins come straight from registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg_q <= SEG_MASK;
    end else if (rst_sync_q[1] && ready) begin
      seg_q <= seg_dat ^ SEG_MASK;
    end
  end

  assign {s0, s1, s2, s3, s4, s5, s6} = seg_q;

endmodule

// File: tb/tb_notas_xylo.sv
// Bench for notas_xylo: directed vector table, reset corner sequences and randomized model comparison.
module tb_notas_xylo;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic ready = 1'b0;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  logic [6:0] seg_h;
  logic [6:0] seg_l;

  int tests = 0;
  int failed = 0;

  // Reference state: displayed pattern (active-high) and edges seen since reset release.
  logic [6:0] exp_seg = 7'b0000000;
  int rel_edges = 0;

  always #5 clock = ~clock;

  notas_xylo #(.SEG_ACTIVE_LOW(1'b0)) dut_h (
    .clock(clock), .reset(reset), .ready(ready), .a(a), .b(b), .c(c), .d(d),
    .s0(seg_h[6]), .s1(seg_h[5]), .s2(seg_h[4]), .s3(seg_h[3]),
    .s4(seg_h[2]), .s5(seg_h[1]), .s6(seg_h[0])
  );

  notas_xylo #(.SEG_ACTIVE_LOW(1'b1)) dut_l (
    .clock(clock), .reset(reset), .ready(ready), .a(a), .b(b), .c(c), .d(d),
    .s0(seg_l[6]), .s1(seg_l[5]), .s2(seg_l[4]), .s3(seg_l[3]),
    .s4(seg_l[2]), .s5(seg_l[1]), .s6(seg_l[0])
  );

  typedef struct {
    logic [3:0] code;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[16];

  // Letters C d E F G A b indexed by note number; anything else is a dash.
  function automatic logic [6:0] note_pattern(input logic [3:0] code);
    logic [6:0] letters[7];
    int idx;
    letters = '{7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111,
                7'b1011110, 7'b1110111, 7'b0011111};
    idx = int'(code) % 8;
    if (idx == 7) return 7'b0000001;
    return letters[idx];
  endfunction

  task automatic check(input string name, input logic [6:0] exp);
    tests++;
    if (seg_h !== exp) begin
      failed++;
      $display("FAIL %s (active-high): got %b expected %b", name, seg_h, exp);
    end
    tests++;
    if (seg_l !== ~exp) begin
      failed++;
      $display("FAIL %s (active-low): got %b expected %b", name, seg_l, ~exp);
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic [3:0] code);
    {a, b, c, d} = code;
    ready = rdy;
    reset = rst;
    if (!rst) begin
      exp_seg = 7'b0000000;
      rel_edges = 0;
    end
  endtask

  // One rising edge, the model's view of it, then settle before sampling.
  task automatic tick();
    @(posedge clock);
    if (reset) begin
      if (rel_edges >= 2 && ready) exp_seg = note_pattern({a, b, c, d});
      if (rel_edges < 2) rel_edges++;
    end
    #2;
  endtask

  initial begin
    tbl[0]  = '{4'b0000, 7'b1001110};
    tbl[1]  = '{4'b0001, 7'b0111101};
    tbl[2]  = '{4'b0010, 7'b1001111};
    tbl[3]  = '{4'b0011, 7'b1000111};
    tbl[4]  = '{4'b0100, 7'b1011110};
    tbl[5]  = '{4'b0101, 7'b1110111};
    tbl[6]  = '{4'b0110, 7'b0011111};
    tbl[7]  = '{4'b0111, 7'b0000001};
    tbl[8]  = '{4'b1000, 7'b1001110};
    tbl[9]  = '{4'b1001, 7'b0111101};
    tbl[10] = '{4'b1010, 7'b1001111};
    tbl[11] = '{4'b1011, 7'b1000111};
    tbl[12] = '{4'b1100, 7'b1011110};
    tbl[13] = '{4'b1101, 7'b1110111};
    tbl[14] = '{4'b1110, 7'b0011111};
    tbl[15] = '{4'b1111, 7'b0000001};

    // Reset assertion blanks without a clock edge.
    #1;
    drive(1'b0, 1'b0, 4'b0000);
    #1;
    check("reset_immediate", 7'b0000000);
    tick();
    tick();
    check("reset_held", 7'b0000000);

    drive(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 4'(i * 3));
      tick();
      check("blank_before_load", 7'b0000000);
    end

    // Single load of C, then hold while the code wanders.
    drive(1'b1, 1'b1, 4'b0000);
    tick();
    check("load_c", 7'b1001110);
    for (int i = 1; i < 16; i += 4) begin
      drive(1'b1, 1'b0, 4'(i));
      tick();
      check("hold_c", 7'b1001110);
    end

    // Every code once, ready held high.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b1, tbl[i].code);
      tick();
      check($sformatf("table_code_%0d", i), tbl[i].exp);
    end

    // Mid-cycle reset after an A, then recovery through the synchroniser to E.
    drive(1'b1, 1'b1, 4'b0101);
    tick();
    check("load_a", 7'b1110111);
    drive(1'b1, 1'b0, 4'b0101);
    #2;
    drive(1'b0, 1'b1, 4'b0011);
    #1;
    check("reset_mid_cycle", 7'b0000000);
    tick();
    check("ready_during_reset", 7'b0000000);
    drive(1'b1, 1'b1, 4'b0010);
    tick();
    check("sync_edge1_blank", 7'b0000000);
    tick();
    check("sync_edge2_blank", 7'b0000000);
    tick();
    check("load_e_after_reset", 7'b1001111);

    // Reset falling and ready rising together before an edge.
    drive(1'b1, 1'b0, 4'b0011);
    #2;
    drive(1'b0, 1'b1, 4'b0011);
    tick();
    check("reset_and_ready_same_edge", 7'b0000000);
    drive(1'b1, 1'b0, 4'b0011);
    tick();
    tick();
    drive(1'b1, 1'b1, 4'b0011);
    tick();
    check("load_f", 7'b1000111);

    // Randomized traffic against the reference model, with occasional resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 24) != 0), ($urandom_range(0, 1) == 1),
            4'($urandom_range(0, 15)));
      #1;
      check("rand_pre_edge", exp_seg);
      tick();
      check("rand_post_edge", exp_seg);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
